branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port id_valid, input, 1 bit: the ID stage holds a control-transfer candidate.
REQ-004 SHALL have port id_kind, input, 2 bits: 0 none, 1 conditional branch, 2 JAL, 3 JALR.
REQ-005 SHALL have ports id_funct3 (input, 3 bits) and id_pc, id_imm, rs1_data (inputs, 32 bits each).
REQ-006 SHALL have port operands_ready, input, 1 bit: forwarded rs1/rs2 values are valid this cycle.
REQ-007 SHALL have port cmp_sel, output, 3 bits: select to the comparison unit (0 eq, 1 ne, 2 ltu, 3 lt, 4 gtu, 5 gt).
REQ-008 SHALL have port cmp_flag, input, 1 bit: the comparison result, valid in the same cycle as cmp_sel.
REQ-009 SHALL have ports redirect_valid (output, 1 bit), redirect_pc (output, 32 bits) and redirect_ready (input, 1 bit) forming a valid/ready handshake to IF.
REQ-010 SHALL have output ports id_stall, if_id_flush, illegal_branch and misaligned_target, 1 bit each.

Function
REQ-011 SHALL decode cmp_sel combinationally from id_funct3:
- 000 -> 0; 001 -> 1; 100 -> 3; 101 -> 3 with invert; 110 -> 2; 111 -> 2 with invert.
- All other encodings -> 0.
REQ-012 SHALL compute taken as follows:
- Conditional branch: cmp_flag XOR invert.
- JAL and JALR: always 1.
REQ-013 SHALL compute the target as follows:
- Branch and JAL: id_pc + id_imm, modulo 2^32.
- JALR: (rs1_data + id_imm) with bit 0 cleared, modulo 2^32.
REQ-014 SHALL implement states IDLE, WAIT_OPS and REDIRECT.
REQ-015 In IDLE, SHALL take these transitions:
- id_valid with id_kind != 0 and operands_ready low -> WAIT_OPS.
- id_valid with id_kind != 0 and operands_ready high -> resolve in the same cycle.
REQ-016 On resolve, SHALL act as follows:
- Taken, and target bits [1:0] == 00 -> register redirect_pc and enter REDIRECT on the next edge.
- Not taken -> stay in IDLE.
REQ-017 In WAIT_OPS, SHALL assert id_stall, and SHALL resolve per REQ-016 when operands_ready rises.
REQ-018 In REDIRECT, SHALL assert redirect_valid and hold redirect_pc stable until redirect_ready is sampled high.
REQ-019 When the REDIRECT handshake completes, SHALL behave as follows:
- Pulse if_id_flush for exactly that cycle.
- Return to IDLE.
REQ-020 SHALL assert id_stall in REDIRECT while redirect_ready is low.
REQ-021 SHALL treat a conditional branch with funct3 010 or 011 as follows:
- Pulse illegal_branch for one cycle.
- Treat it as not taken.
REQ-022 SHALL treat a taken target with bits [1:0] != 00 as follows:
- Pulse misaligned_target for one cycle.
- Issue no redirect and return to IDLE.
REQ-023 SHALL ignore id_valid while in REDIRECT; the upstream stage is held by id_stall.
REQ-024 SHALL have a resolve-to-redirect_valid latency of exactly 1 cycle, and a minimum redirect_valid duration of 1 cycle.
REQ-025 When id_valid is low, SHALL keep the state unchanged, except that REDIRECT still completes its handshake.

Reset
REQ-026 While rst_n is low, SHALL force the following, independent of clk:
- State IDLE.
- redirect_valid, id_stall, if_id_flush, illegal_branch and misaligned_target all 0.
- redirect_pc 32'h0000_0000.
REQ-027 Reset asserted mid-REDIRECT SHALL drop redirect_valid without producing a flush pulse.
REQ-028 Release of rst_n SHALL allow the first resolve on the following rising edge.

Structure
REQ-029 SHALL place the following in a shared ID-stage package:
- The state enum.
- id_kind encodings.
- cmp_sel encodings.
- funct3 constants.
REQ-030 SHALL place the funct3-to-sel/invert decode in one combinational sub-module named branch_cond_decode; all state stays in the parent.

Verification
REQ-031 Bench SHALL check BEQ taken as follows:
- Stimulus: pc 0x100, imm 0x20, cmp_flag 1, funct3 000, redirect_ready 1.
- Required: cmp_sel 0; redirect_valid and redirect_pc 0x120 one cycle later; if_id_flush pulses once.
REQ-032 Bench SHALL check BGEU not taken as follows:
- Stimulus: funct3 111, cmp_flag 1 (a<b).
- Required: cmp_sel 2; no redirect; state stays IDLE.
REQ-033 Bench SHALL check JALR as follows:
- Stimulus: rs1 0x1003, imm 0x5, operands_ready low for 3 cycles, then high.
- Required: id_stall high for 3 cycles; redirect_pc 0x1008.
REQ-034 Bench SHALL check backpressure as follows:
- Stimulus: redirect_ready held low for 4 cycles.
- Required: redirect_valid and redirect_pc stable and id_stall high throughout; flush only in the accept cycle.
REQ-035 Bench SHALL check the error pulses as follows:
- Stimulus 1: funct3 010 -> illegal_branch pulses once, no redirect.
- Stimulus 2: JAL with pc 0x100, imm 0x6 -> misaligned_target pulses once, no redirect.
REQ-036 Bench SHALL check reset in REDIRECT as follows:
- Stimulus: rst_n low while in REDIRECT.
- Required: redirect_valid goes 0 immediately, and if_id_flush stays 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared ID-stage definitions for branch resolution.
// Contents: the resolver state enum, the id_kind encodings, the cmp_sel
// encodings, the funct3 constants and a helper that flags reserved branch funct3.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OPS = 2'd1,
    ST_REDIRECT = 2'd2
  } bru_state_t;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_JALR   = 2'd3
  } id_kind_t;

  typedef enum logic [2:0] {
    SEL_EQ  = 3'd0,
    SEL_NE  = 3'd1,
    SEL_LTU = 3'd2,
    SEL_LT  = 3'd3,
    SEL_GTU = 3'd4,
    SEL_GT  = 3'd5
  } cmp_sel_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV2 = 3'b010;
  localparam logic [2:0] F3_RSV3 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic f3_reserved(input logic [2:0] f3);
    return (f3 == F3_RSV2) || (f3 == F3_RSV3);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_decode.sv
// branch_cond_decode: combinational funct3 decode for conditional branches.
// Ports:
//   funct3  in  [2:0]  branch funct3 from ID
//   sel     out [2:0]  comparison select (cmp_sel encoding)
//   invert  out        invert the comparison result (BGE/BGEU)
//   illegal out        funct3 is a reserved branch encoding
module branch_cond_decode
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] funct3,
  output logic [2:0] sel,
  output logic       invert,
  output logic       illegal
);

  always_comb begin
    sel     = SEL_EQ;
    invert  = 1'b0;
    illegal = f3_reserved(funct3);
    case (funct3)
      F3_BEQ:  sel = SEL_EQ;
      F3_BNE:  sel = SEL_NE;
      F3_BLT:  sel = SEL_LT;
      F3_BGE:  begin sel = SEL_LT;  invert = 1'b1; end
      F3_BLTU: sel = SEL_LTU;
      F3_BGEU: begin sel = SEL_LTU; invert = 1'b1; end
      default: sel = SEL_EQ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches/JAL/JALR in ID and redirects IF.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_valid, id_kind, id_funct3     control-transfer candidate from ID
//   id_pc, id_imm, rs1_data          target operands
//   operands_ready                   forwarded rs1/rs2 valid this cycle
//   cmp_sel / cmp_flag               select to / result from comparison unit
//   redirect_valid/_pc/_ready        valid/ready redirect handshake to IF
//   id_stall, if_id_flush            pipeline control
//   illegal_branch, misaligned_target one-cycle error pulses
//
// state        | meaning
// ST_IDLE      | no pending transfer; resolves immediately if operands ready
// ST_WAIT_OPS  | candidate held in ID, stalling until operands_ready
// ST_REDIRECT  | redirect_pc presented to IF, waiting for redirect_ready
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [1:0]  id_kind,
  input  logic [2:0]  id_funct3,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [31:0] rs1_data,
  input  logic        operands_ready,
  output logic [2:0]  cmp_sel,
  input  logic        cmp_flag,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        id_stall,
  output logic        if_id_flush,
  output logic        illegal_branch,
  output logic        misaligned_target
);

  bru_state_t  state_q, state_d;
  logic [31:0] redirect_pc_q;
  logic        load_pc;
  logic        dec_invert, dec_illegal;
  logic        is_branch, is_ctl, taken;
  logic [31:0] jalr_sum, target;
  logic        stall_c, flush_c, illegal_c, misal_c;

  branch_cond_decode u_cond_decode (
    .funct3  (id_funct3),
    .sel     (cmp_sel),
    .invert  (dec_invert),
    .illegal (dec_illegal)
  );

  assign is_branch = (id_kind == KIND_BRANCH);
  assign is_ctl    = id_valid && (id_kind != KIND_NONE);
  // Reserved branch encodings are never taken.
  assign taken     = is_branch ? (!dec_illegal && (cmp_flag ^ dec_invert)) : 1'b1;
  assign jalr_sum  = rs1_data + id_imm;
  assign target    = (id_kind == KIND_JALR) ? (jalr_sum & 32'hFFFF_FFFE)
                                            : (id_pc + id_imm);

  always_comb begin
    state_d   = state_q;
    load_pc   = 1'b0;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    illegal_c = 1'b0;
    misal_c   = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT_OPS: begin
        // A candidate in WAIT_OPS stays stalled even if id_valid drops.
        if (state_q == ST_WAIT_OPS) stall_c = 1'b1;
        if (is_ctl) begin
          if (!operands_ready) begin
            stall_c = 1'b1;
            state_d = ST_WAIT_OPS;
          end else begin
            stall_c   = 1'b0;
            state_d   = ST_IDLE;
            illegal_c = is_branch && dec_illegal;
            if (taken) begin
              if (target[1:0] != 2'b00) begin
                misal_c = 1'b1;
              end else begin
                load_pc = 1'b1;
                state_d = ST_REDIRECT;
              end
            end
          end
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          flush_c = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      if (load_pc) redirect_pc_q <= target;
    end
  end

  // Combinational outputs are gated so reset silences them without a clock.
  assign redirect_valid    = (state_q == ST_REDIRECT);
  assign redirect_pc       = redirect_pc_q;
  assign id_stall          = rst_n && stall_c;
  assign if_id_flush       = rst_n && flush_c;
  assign illegal_branch    = rst_n && illegal_c;
  assign misaligned_target = rst_n && misal_c;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [1:0]  id_kind;
  logic [2:0]  id_funct3;
  logic [31:0] id_pc, id_imm, rs1_data;
  logic        operands_ready;
  logic [2:0]  cmp_sel;
  logic        cmp_flag;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        id_stall, if_id_flush, illegal_branch, misaligned_target;

  int passed = 0;
  int total  = 0;

  branch_resolve_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_valid          (id_valid),
    .id_kind           (id_kind),
    .id_funct3         (id_funct3),
    .id_pc             (id_pc),
    .id_imm            (id_imm),
    .rs1_data          (rs1_data),
    .operands_ready    (operands_ready),
    .cmp_sel           (cmp_sel),
    .cmp_flag          (cmp_flag),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .redirect_ready    (redirect_ready),
    .id_stall          (id_stall),
    .if_id_flush       (if_id_flush),
    .illegal_branch    (illegal_branch),
    .misaligned_target (misaligned_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        flag;
    logic [2:0]  sel;
    logic        ill;
    logic        mis;
    logic        redir;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic flag);
    id_valid  = 1'b1;
    id_kind   = kind;
    id_funct3 = f3;
    id_pc     = pc;
    id_imm    = imm;
    rs1_data  = rs1;
    cmp_flag  = flag;
  endtask

  initial begin
    //           name        kind  f3      pc            imm           rs1           flg sel  ill mis red tgt
    vecs[0]  = '{"beq_t",    2'd1, 3'b000, 32'h100,      32'h20,       32'h0,        1, 3'd0, 0, 0, 1, 32'h120};
    vecs[1]  = '{"bne_nt",   2'd1, 3'b001, 32'h100,      32'h20,       32'h0,        0, 3'd1, 0, 0, 0, 32'h0};
    vecs[2]  = '{"blt_t",    2'd1, 3'b100, 32'h200,      32'hFFFF_FFF0, 32'h0,       1, 3'd3, 0, 0, 1, 32'h1F0};
    vecs[3]  = '{"bge_t",    2'd1, 3'b101, 32'h40,       32'h8,        32'h0,        0, 3'd3, 0, 0, 1, 32'h48};
    vecs[4]  = '{"bgeu_nt",  2'd1, 3'b111, 32'h100,      32'h40,       32'h0,        1, 3'd2, 0, 0, 0, 32'h0};
    vecs[5]  = '{"bltu_wrap",2'd1, 3'b110, 32'hFFFF_FFFC, 32'h8,       32'h0,        1, 3'd2, 0, 0, 1, 32'h4};
    vecs[6]  = '{"ill_010",  2'd1, 3'b010, 32'h100,      32'h20,       32'h0,        1, 3'd0, 1, 0, 0, 32'h0};
    vecs[7]  = '{"jal_mis",  2'd2, 3'b000, 32'h100,      32'h6,        32'h0,        0, 3'd0, 0, 1, 0, 32'h0};
    vecs[8]  = '{"jalr",     2'd3, 3'b000, 32'h0,        32'h5,        32'h1003,     0, 3'd0, 0, 0, 1, 32'h1008};
    vecs[9]  = '{"jalr_b0",  2'd3, 3'b000, 32'h0,        32'h0,        32'h1001,     0, 3'd0, 0, 0, 1, 32'h1000};
    vecs[10] = '{"jalr_mis", 2'd3, 3'b000, 32'h0,        32'h0,        32'h2,        0, 3'd0, 0, 1, 0, 32'h0};
    vecs[11] = '{"none",     2'd0, 3'b001, 32'h100,      32'h20,       32'h0,        1, 3'd1, 0, 0, 0, 32'h0};
    vecs[12] = '{"ill_011",  2'd1, 3'b011, 32'h100,      32'h20,       32'h0,        0, 3'd0, 1, 0, 0, 32'h0};
    vecs[13] = '{"jal_f3",   2'd2, 3'b011, 32'h10,       32'h10,       32'h0,        0, 3'd0, 0, 0, 1, 32'h20};

    // Reset with an active illegal candidate: every output must stay quiet.
    rst_n = 1'b0;
    operands_ready = 1'b1;
    redirect_ready = 1'b1;
    drive(2'd1, 3'b010, 32'h100, 32'h4, 32'h0, 1'b1);
    #2;
    chk("rst_rv",    {31'd0, redirect_valid},    32'd0);
    chk("rst_pc",    redirect_pc,                32'd0);
    chk("rst_stall", {31'd0, id_stall},          32'd0);
    chk("rst_flush", {31'd0, if_id_flush},       32'd0);
    chk("rst_ill",   {31'd0, illegal_branch},    32'd0);
    chk("rst_mis",   {31'd0, misaligned_target}, 32'd0);
    @(negedge clk);
    id_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      #1;
      chk({vecs[i].name, "_idle_rv"}, {31'd0, redirect_valid}, 32'd0);
      drive(vecs[i].kind, vecs[i].f3, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].flag);
      operands_ready = 1'b1;
      redirect_ready = 1'b1;
      #1;
      chk({vecs[i].name, "_sel"},   {29'd0, cmp_sel},           {29'd0, vecs[i].sel});
      chk({vecs[i].name, "_ill"},   {31'd0, illegal_branch},    {31'd0, vecs[i].ill});
      chk({vecs[i].name, "_mis"},   {31'd0, misaligned_target}, {31'd0, vecs[i].mis});
      chk({vecs[i].name, "_stall"}, {31'd0, id_stall},          32'd0);
      @(negedge clk);
      id_valid = 1'b0;
      #1;
      chk({vecs[i].name, "_rv"},    {31'd0, redirect_valid}, {31'd0, vecs[i].redir});
      chk({vecs[i].name, "_flush"}, {31'd0, if_id_flush},    {31'd0, vecs[i].redir});
      chk({vecs[i].name, "_ill2"},  {31'd0, illegal_branch},    32'd0);
      chk({vecs[i].name, "_mis2"},  {31'd0, misaligned_target}, 32'd0);
      if (vecs[i].redir) chk({vecs[i].name, "_pc"}, redirect_pc, vecs[i].tgt);
      @(negedge clk);
    end

    // JALR waiting three cycles for operands.
    drive(2'd3, 3'b000, 32'h0, 32'h5, 32'h1003, 1'b0);
    operands_ready = 1'b0;
    redirect_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wait_stall", {31'd0, id_stall},       32'd1);
      chk("wait_rv",    {31'd0, redirect_valid}, 32'd0);
      @(negedge clk);
    end
    operands_ready = 1'b1;
    #1;
    chk("wait_resolve_stall", {31'd0, id_stall}, 32'd0);
    @(negedge clk);
    id_valid = 1'b0;
    #1;
    chk("wait_rv_after", {31'd0, redirect_valid}, 32'd1);
    chk("wait_pc",       redirect_pc,             32'h1008);
    chk("wait_flush",    {31'd0, if_id_flush},    32'd1);
    @(negedge clk);

    // Backpressure for 4 cycles, with a competing JAL that must be ignored.
    drive(2'd1, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1);
    redirect_ready = 1'b0;
    @(negedge clk);
    drive(2'd2, 3'b000, 32'h400, 32'h40, 32'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_rv",    {31'd0, redirect_valid}, 32'd1);
      chk("bp_pc",    redirect_pc,             32'h120);
      chk("bp_stall", {31'd0, id_stall},       32'd1);
      chk("bp_flush", {31'd0, if_id_flush},    32'd0);
      @(negedge clk);
    end
    id_valid = 1'b0;
    redirect_ready = 1'b1;
    #1;
    chk("bp_acc_flush", {31'd0, if_id_flush}, 32'd1);
    chk("bp_acc_stall", {31'd0, id_stall},    32'd0);
    chk("bp_acc_pc",    redirect_pc,          32'h120);
    @(negedge clk);
    #1;
    chk("bp_done_rv",    {31'd0, redirect_valid}, 32'd0);
    chk("bp_done_flush", {31'd0, if_id_flush},    32'd0);
    @(negedge clk);

    // Reset asserted mid-REDIRECT.
    drive(2'd1, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1);
    redirect_ready = 1'b0;
    @(negedge clk);
    id_valid = 1'b0;
    #1;
    chk("rr_pre_rv", {31'd0, redirect_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    redirect_ready = 1'b1;
    #1;
    chk("rr_rv",    {31'd0, redirect_valid}, 32'd0);
    chk("rr_flush", {31'd0, if_id_flush},    32'd0);
    chk("rr_pc",    redirect_pc,             32'd0);
    @(negedge clk);
    #1;
    chk("rr_hold_flush", {31'd0, if_id_flush}, 32'd0);
    // First resolve on the edge right after release.
    drive(2'd1, 3'b000, 32'h300, 32'h4, 32'h0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    id_valid = 1'b0;
    #1;
    chk("rel_rv", {31'd0, redirect_valid}, 32'd1);
    chk("rel_pc", redirect_pc,             32'h304);
    @(negedge clk);
    #1;
    chk("rel_idle_rv", {31'd0, redirect_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
